// File: rtl/zedcam_axi_lite_regs.sv
// -----------------------------------------------------------------------------
// zedcam_axi_lite_regs
//   AXI4-Lite slave register file on the ZedCam control port. It holds four
//   32-bit read/write control registers at byte offsets 0x0/0x4/0x8/0xC and
//   exports their live contents to the camera datapath.
//
//   The write and read channels are independent. Each channel has at most one
//   transaction in flight. An accepted address/data pair produces a one-cycle
//   READY pulse. The register commits at the edge that closes that pulse, and
//   the response goes VALID at the same edge. It stays VALID until the master
//   takes it.
//
// Ports
//   S_AXI_ACLK       clock; all logic on the rising edge
//   S_AXI_ARESET     synchronous active-high reset
//   S_AXI_AW*/W*/B*  write address, write data, write response channels
//   S_AXI_AR*/R*     read address and read data channels
//   ctrl_reg0..3     live register contents to the camera datapath
//
// Notes
//   Only address bits [3:2] are decoded. Higher addresses alias onto the four
//   registers, and bits [1:0] are ignored. The responses are always OKAY. The
//   block supports only C_S_AXI_DATA_WIDTH = 32 and C_S_AXI_ADDR_WIDTH >= 4.
// -----------------------------------------------------------------------------
module zedcam_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg3
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t                      w_state;
  r_state_t                      r_state;
  logic                          aw_ready_q;  // shared AWREADY/WREADY pulse
  logic                          ar_ready_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic [1:0] w_idx;
  logic [1:0] r_idx;
  assign w_idx = S_AXI_AWADDR[3:2];
  assign r_idx = S_AXI_ARADDR[3:2];

  // PROT and the byte-lane address bits carry no meaning for this register file.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel. READY rises one cycle after both VALIDs are seen. The
  // register commits at the edge that closes the READY cycle, and the FSM then
  // waits in W_RESP until BREADY. No new request is accepted in W_RESP.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state    <= W_IDLE;
      aw_ready_q <= 1'b0;
      // NOTE: the register array is reset explicitly because it drives ctrl_reg0..3 directly.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_ready_q) begin
            aw_ready_q <= 1'b0;
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
              for (int b = 0; b < STRB_W; b++)
                if (S_AXI_WSTRB[b]) regs[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
              w_state <= W_RESP;
            end
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            aw_ready_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel. RDATA is captured at the AR handshake edge. If a write
  // commits to the same register at that edge, the read returns the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_ready_q) begin
            ar_ready_q <= 1'b0;
            if (S_AXI_ARVALID) begin
              rdata_q <= regs[r_idx];
              r_state <= R_DATA;
            end
          end else if (S_AXI_ARVALID) begin
            ar_ready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  assign ctrl_reg0 = regs[0];
  assign ctrl_reg1 = regs[1];
  assign ctrl_reg2 = regs[2];
  assign ctrl_reg3 = regs[3];

endmodule

// File: tb/tb_zedcam_axi_lite_regs.sv
// -----------------------------------------------------------------------------
// tb_zedcam_axi_lite_regs
//   Self-checking bench for zedcam_axi_lite_regs. A table of directed
//   write/read vectors covers basic access, byte strobes and address aliasing.
//   Hand-written sequences cover handshake latency, back-pressure on B and R,
//   a same-register read/write collision and reset in the middle of a
//   transaction.
// -----------------------------------------------------------------------------
module tb_zedcam_axi_lite_regs;

  logic        tb_ACLK = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, ctrl_reg0, ctrl_reg1, ctrl_reg2, ctrl_reg3;

  int total = 0;
  int bad   = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  zedcam_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK   (tb_ACLK),
    .S_AXI_ARESET (areset),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .ctrl_reg0    (ctrl_reg0),
    .ctrl_reg1    (ctrl_reg1),
    .ctrl_reg2    (ctrl_reg2),
    .ctrl_reg3    (ctrl_reg3)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // expected RDATA for reads
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: inputs driven after this return are seen by the next edge.
  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"},  wready,  0);
    check({tag, "_bvalid"},  bvalid,  0);
    check({tag, "_bresp"},   bresp,   0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_rvalid"},  rvalid,  0);
    check({tag, "_rdata"},   rdata,   0);
    check({tag, "_rresp"},   rresp,   0);
    check({tag, "_ctrl0"},   ctrl_reg0, 0);
    check({tag, "_ctrl1"},   ctrl_reg1, 0);
    check({tag, "_ctrl2"},   ctrl_reg2, 0);
    check({tag, "_ctrl3"},   ctrl_reg3, 0);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input string name);
    bit got = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (awready) got = 1;
    end
    check({name, "_awready_seen"}, got, 1);
    check({name, "_wready"}, wready, got);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check({name, "_bvalid"}, bvalid, 1);
    check({name, "_bresp"},  bresp,  0);
    step();
    check({name, "_bvalid_drop"}, bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    bit got = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (arready) got = 1;
    end
    check({name, "_arready_seen"}, got, 1);
    step();
    arvalid = 1'b0;
    check({name, "_rvalid"}, rvalid, 1);
    check({name, "_rdata"},  rdata,  exp);
    check({name, "_rresp"},  rresp,  0);
    step();
    check({name, "_rvalid_drop"}, rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 32'h0101FFFF, 4'hF, 32'h0,        "wr_r0"};
    vecs[1]  = '{1'b1, 4'h4, 32'hABCD0001, 4'hF, 32'h0,        "wr_r1"};
    vecs[2]  = '{1'b1, 4'h8, 32'hDEAD0011, 4'hF, 32'h0,        "wr_r2"};
    vecs[3]  = '{1'b1, 4'hC, 32'hBEEF0011, 4'hF, 32'h0,        "wr_r3"};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0101FFFF, "rd_r0"};
    vecs[5]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'hABCD0001, "rd_r1"};
    vecs[6]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'hDEAD0011, "rd_r2"};
    vecs[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hBEEF0011, "rd_r3"};
    vecs[8]  = '{1'b1, 4'h4, 32'h11223344, 4'h5, 32'h0,        "wr_r1_strb0101"};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'hAB220044, "rd_r1_strb"};
    vecs[10] = '{1'b1, 4'hF, 32'h77000000, 4'h8, 32'h0,        "wr_r3_alias_b3"};
    vecs[11] = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h77EF0011, "rd_r3_b3"};
    vecs[12] = '{1'b1, 4'h0, 32'h00000000, 4'h0, 32'h0,        "wr_r0_nostrb"};
    vecs[13] = '{1'b0, 4'h1, 32'h0,        4'h0, 32'h0101FFFF, "rd_r0_alias"};

    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    step();
    check_all_zero("reset");
    step();
    areset = 1'b0;
    step();

    // Directed table: basic access, byte strobes, aliasing
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].name);
      else               axi_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    check("tbl_ctrl0", ctrl_reg0, 32'h0101FFFF);
    check("tbl_ctrl1", ctrl_reg1, 32'hAB220044);
    check("tbl_ctrl2", ctrl_reg2, 32'hDEAD0011);
    check("tbl_ctrl3", ctrl_reg3, 32'h77EF0011);

    // AWVALID alone for five cycles, then WVALID joins
    awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; bready = 1'b0;
    awvalid = 1'b1; wvalid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("aw_only_c%0d_awready", c), awready, 0);
    end
    wvalid = 1'b1;
    check("late_w_c6_awready", awready, 0);
    step();
    check("late_w_c7_awready", awready, 1);
    check("late_w_c7_wready",  wready,  1);
    check("late_w_c7_bvalid",  bvalid,  0);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("late_w_c8_awready", awready, 0);
    check("late_w_c8_wready",  wready,  0);
    check("late_w_c8_bvalid",  bvalid,  1);
    check("late_w_c8_ctrl2",   ctrl_reg2, 32'h12345678);

    // BREADY held low with a second write pending
    awaddr = 4'hC; wdata = 32'h0BADCAFE; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bhold_c%0d_bvalid", c),  bvalid,  1);
      check($sformatf("bhold_c%0d_awready", c), awready, 0);
    end
    bready = 1'b1;
    step();
    check("bhs_bvalid",      bvalid,  0);
    check("bhs_awready",     awready, 0);
    step();
    check("bhs_p1_awready",  awready, 1);
    check("bhs_p1_wready",   wready,  1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("w2_bvalid", bvalid, 1);
    check("w2_ctrl3",  ctrl_reg3, 32'h0BADCAFE);
    step();
    check("w2_bvalid_drop", bvalid, 0);

    // RREADY held low for 8 cycles while a write to another register runs
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    step();
    check("rhold_arready", arready, 1);
    step();
    check("rhold_rvalid", rvalid, 1);
    check("rhold_rdata",  rdata,  32'hAB220044);
    araddr = 4'h8;   // second read request waits behind the held R beat
    awaddr = 4'h8; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("rhold_c%0d_rvalid", c),  rvalid,  1);
      check($sformatf("rhold_c%0d_rdata", c),   rdata,   32'hAB220044);
      check($sformatf("rhold_c%0d_arready", c), arready, 0);
      if (c == 0) check("rhold_w_awready", awready, 1);
      if (c == 1) begin
        check("rhold_w_bvalid", bvalid, 1);
        check("rhold_w_ctrl2",  ctrl_reg2, 32'h55AA55AA);
        awvalid = 1'b0; wvalid = 1'b0;
      end
      if (c == 2) check("rhold_w_bvalid_drop", bvalid, 0);
    end
    rready = 1'b1;
    step();
    check("rhold_rvalid_drop", rvalid,  0);
    check("rhold_ar2_wait",    arready, 0);
    step();
    check("ar2_arready", arready, 1);
    step();
    arvalid = 1'b0;
    check("ar2_rvalid", rvalid, 1);
    check("ar2_rdata",  rdata,  32'h55AA55AA);
    step();
    check("ar2_rvalid_drop", rvalid, 0);

    // Read and write of reg3 commit at the same edge: read sees the old value
    araddr = 4'hC; arvalid = 1'b1; rready = 1'b1;
    awaddr = 4'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    check("coll_arready", arready, 1);
    check("coll_awready", awready, 1);
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coll_rvalid", rvalid, 1);
    check("coll_rdata",  rdata,  32'h0BADCAFE);
    check("coll_bvalid", bvalid, 1);
    check("coll_ctrl3",  ctrl_reg3, 32'hCAFEF00D);
    step();

    // Reset while B and R beats are both pending
    awaddr = 4'h4; wdata = 32'h99999999; wstrb = 4'hF; bready = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    step();
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("prerst_bvalid", bvalid, 1);
    check("prerst_rvalid", rvalid, 1);
    check("prerst_ctrl0",  ctrl_reg0, 32'h0101FFFF);
    areset = 1'b1;
    step();
    check_all_zero("midrst");
    areset = 1'b0;
    bready = 1'b0; rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("postrst_c%0d_bvalid", c), bvalid, 0);
      check($sformatf("postrst_c%0d_rvalid", c), rvalid, 0);
    end
    axi_read(4'h0, 32'h00000000, "postrst_rd_r0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
